// File: rtl/adc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_pkg -- shared parameter defaults and FSM state encoding.  Rev 1.0
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_BITS_DEFAULT   = 10;
  localparam int FIFO_DEPTH_DEFAULT = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t CONVERT = 2'd1;
  localparam state_t CAPTURE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_sample_fifo -- first-word-fall-through sample buffer.  Rev 1.0
// ---------------------------------------------------------------------------
module adc_sample_fifo
  import adc_pkg::*;
#(
  parameter int DATA_BITS = ADC_BITS_DEFAULT,
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [DATA_BITS-1:0]    push_data,
  input  logic                    pop,
  output logic [DATA_BITS-1:0]    pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_capture -- conversion sequencer, sample buffer and sticky overflow.  Rev 1.0
// ---------------------------------------------------------------------------
module adc_capture
  import adc_pkg::*;
#(
  parameter int ADC_BITS   = ADC_BITS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         continuous,
  output logic                         adc_enable,
  input  logic [ADC_BITS-1:0]          adc_code,
  output logic [ADC_BITS-1:0]          m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow,
  input  logic                         clear_ovf
);

  localparam int            BW       = $clog2(ADC_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(ADC_BITS - 1);

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] bit_cnt;
  logic          enable_next;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start || continuous) state_next = CONVERT;
      CONVERT: if (bit_cnt == BIT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = continuous ? CONVERT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enable_next = (state_next == CONVERT);
    push        = (state == CAPTURE);
    busy        = (state != IDLE);
  end

  // adc_enable is registered from the next state so it lines up with CONVERT glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      adc_enable <= 1'b0;
    end else begin
      bit_cnt    <= (state == CONVERT && bit_cnt != BIT_LAST) ? bit_cnt + 1'b1 : '0;
      adc_enable <= enable_next;
    end
  end

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign drop    = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  adc_sample_fifo #(
    .DATA_BITS (ADC_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (adc_code),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adc_capture -- scoreboard bench for adc_capture.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_adc_capture;

  localparam int AB = 10;
  localparam int FD = 8;

  logic                 clk        = 1'b0;
  logic                 reset_n    = 1'b0;
  logic                 start      = 1'b0;
  logic                 continuous = 1'b0;
  logic                 m_ready    = 1'b0;
  logic                 clear_ovf  = 1'b0;
  logic [AB-1:0]        adc_code   = '0;
  logic                 adc_enable;
  logic                 m_valid;
  logic                 busy;
  logic                 overflow;
  logic [AB-1:0]        m_data;
  logic [$clog2(FD):0]  count;

  int            tests_run    = 0;
  int            tests_failed = 0;
  int            en_cnt;
  logic [AB-1:0] sb [$];
  logic [AB-1:0] exp_data;

  always #5 clk = ~clk;

  adc_capture #(
    .ADC_BITS   (AB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .continuous (continuous),
    .adc_enable (adc_enable),
    .adc_code   (adc_code),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .count      (count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer side: every accepted beat is matched against the oldest expected sample.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_extra_beat", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        exp_data = sb.pop_front();
        check_val("m_data", 32'(m_data), 32'(exp_data));
      end
    end
  end

  task automatic drain(input int n);
    m_ready = 1'b1;
    cyc(n);
    m_ready = 1'b0;
  endtask

  task automatic shot(input logic [AB-1:0] code, input bit expect_out);
    adc_code = code;
    start    = 1'b1;
    if (expect_out) sb.push_back(code);
    cyc(1);
    start = 1'b0;
    cyc(12);
  endtask

  // Nine continuous conversions into an empty buffer; code k is driven mid-conversion k.
  task automatic fill(input logic [AB-1:0] base, input bit pop_last, input bit clr_last);
    continuous = 1'b1;
    adc_code   = AB'(base + 1);
    sb.push_back(AB'(base + 1));
    cyc(5);
    for (int k = 2; k <= 9; k++) begin
      cyc(11);
      adc_code = AB'(base + k);
      if (k <= 8 || pop_last) sb.push_back(AB'(base + k));
    end
    check_val("fill_count8", 32'(count), 32'd8);
    check_val("fill_ovf_pre", 32'(overflow), 32'd0);
    continuous = 1'b0;
    cyc(6);
    check_val("fill_cap_en", 32'(adc_enable), 32'd0);
    check_val("fill_cap_busy", 32'(busy), 32'd1);
    m_ready   = pop_last;
    clear_ovf = clr_last;
    cyc(1);
    m_ready   = 1'b0;
    clear_ovf = 1'b0;
    check_val("fill_count_post", 32'(count), 32'd8);
    check_val("fill_ovf_post", 32'(overflow), pop_last ? 32'd0 : 32'd1);
    check_val("fill_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    check_val("rst_en", 32'(adc_enable), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(m_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Single shot: enable width and start-to-valid latency.
    adc_code = 10'h2A5;
    start    = 1'b1;
    sb.push_back(10'h2A5);
    cyc(1);
    start  = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (adc_enable) en_cnt++;
      if (i == 10) begin
        check_val("t1_valid_early", 32'(m_valid), 32'd0);
        check_val("t1_en_capture", 32'(adc_enable), 32'd0);
      end
      cyc(1);
    end
    check_val("t1_en_cycles", 32'(en_cnt), 32'd10);
    check_val("t1_valid", 32'(m_valid), 32'd1);
    check_val("t1_data", 32'(m_data), 32'h2A5);
    check_val("t1_count", 32'(count), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd0);
    drain(1);
    check_val("t1_count_drained", 32'(count), 32'd0);

    // Overflow: ninth sample dropped, first eight returned in order.
    fill(10'h000, 1'b0, 1'b0);
    drain(8);
    check_val("t2_count_drained", 32'(count), 32'd0);
    check_val("t2_ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    check_val("t2_ovf_cleared", 32'(overflow), 32'd0);

    // Full buffer with a pop during the ninth capture.
    fill(10'h100, 1'b1, 1'b0);
    drain(8);
    check_val("t3_count_drained", 32'(count), 32'd0);

    // Clear coinciding with a drop loses to the drop.
    fill(10'h200, 1'b0, 1'b1);
    clear_ovf = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    check_val("t4_ovf_cleared", 32'(overflow), 32'd0);
    drain(8);

    // start while busy is ignored.
    adc_code = 10'h0AA;
    start    = 1'b1;
    sb.push_back(10'h0AA);
    cyc(1);
    start = 1'b0;
    cyc(4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(6);
    check_val("t5_count", 32'(count), 32'd1);
    cyc(15);
    check_val("t5_count_later", 32'(count), 32'd1);
    check_val("t5_idle", 32'(busy), 32'd0);
    drain(1);

    // Reset mid-conversion with three samples buffered.
    shot(10'h011, 1'b0);
    shot(10'h022, 1'b0);
    shot(10'h033, 1'b0);
    check_val("t6_count3", 32'(count), 32'd3);
    adc_code = 10'h3FF;
    start    = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    check_val("t6_en_mid", 32'(adc_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_en", 32'(adc_enable), 32'd0);
    check_val("t6_rst_count", 32'(count), 32'd0);
    check_val("t6_rst_valid", 32'(m_valid), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(20);
    check_val("t6_no_sample", 32'(count), 32'd0);
    check_val("t6_no_valid", 32'(m_valid), 32'd0);
    adc_code = 10'h155;
    start    = 1'b1;
    sb.push_back(10'h155);
    cyc(1);
    start = 1'b0;
    check_val("t6_start_honoured", 32'(adc_enable), 32'd1);
    cyc(11);
    check_val("t6_valid", 32'(m_valid), 32'd1);
    drain(1);

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  ADC_BITS, 10, width of conversion code from ADCregs
  FIFO_DEPTH, 8, sample buffer entries (power of two)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk  input  1  single system clock; all logic on rising edge
  reset_n  input  1  asynchronous active-low reset
  start  input  1  request one conversion; sampled only in IDLE
  continuous  input  1  when high, back-to-back conversions without start
  adc_enable  output  1  drives ADCregs enable during conversion
  adc_code  input  ADC_BITS  ADCregs out bus
  m_data  output  ADC_BITS  oldest buffered sample
  m_valid  output  1  buffer non-empty
  m_ready  input  1  consumer accepts m_data when m_valid&m_ready
  busy  output  1  high in any state other than IDLE
  count  output  log2(FIFO_DEPTH)+1  samples currently buffered
  overflow  output  1  sticky: a sample was dropped
  clear_ovf  input  1  synchronous clear of overflow
REQ-003 Clock SHALL be named clk and reset SHALL be named reset_n; one clock, reset asynchronous and active-low.

Function
REQ-004 FSM SHALL have states IDLE, CONVERT, CAPTURE.
REQ-005 IDLE -> CONVERT when start=1 or continuous=1; otherwise stay IDLE.
REQ-006 In CONVERT adc_enable SHALL be 1 for exactly ADC_BITS consecutive cycles, counted by a bit counter 0..ADC_BITS-1; on counter = ADC_BITS-1 -> CAPTURE.
REQ-007 adc_enable SHALL be 0 in IDLE and CAPTURE; registered output, no glitches.
REQ-008 In CAPTURE adc_code SHALL be pushed into the buffer (one cycle), then -> CONVERT if continuous=1, else IDLE.
REQ-009 start asserted while busy SHALL be ignored (no queuing).
REQ-010 Buffer SHALL be first-word-fall-through: m_data = oldest entry whenever m_valid=1; m_data value is don't-care when m_valid=0.
REQ-011 Pop SHALL occur on m_valid & m_ready; push on CAPTURE cycle.
REQ-012 Push when full and no pop same cycle: sample dropped, contents unchanged, overflow set to 1.
REQ-013 Push when full with pop same cycle: both SHALL occur, count unchanged, no overflow.
REQ-014 Push when empty with m_ready=1: no pop that cycle (m_valid was 0); sample visible on m_valid the next cycle.
REQ-015 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count = pushes - pops, range 0..FIFO_DEPTH.
REQ-016 overflow SHALL remain 1 until clear_ovf=1; if clear_ovf and a new drop coincide, overflow SHALL be 1.
REQ-017 Latency start->first m_valid SHALL be ADC_BITS+2 cycles (1 IDLE decision, ADC_BITS convert, 1 capture).

Reset
REQ-018 On reset_n=0, immediately: state IDLE, bit counter 0, adc_enable 0, busy 0, pointers 0, count 0, m_valid 0, overflow 0.
REQ-019 Reset asserted mid-conversion SHALL abort it; no partial sample pushed; buffered samples discarded.
REQ-020 After reset_n rises, first start SHALL be honoured on the next rising edge.

Structure
REQ-021 Package adc_pkg SHALL hold ADC_BITS, FIFO_DEPTH defaults and the FSM state encoding.
REQ-022 Buffer SHALL be a sub-module adc_sample_fifo (push, pop, data, full, empty, count); FSM and overflow logic in adc_capture.

Verification
REQ-023 Single shot: start pulse 1 cycle, adc_code=10'h2A5 -> adc_enable high 10 cycles, m_valid at cycle 12, m_data=10'h2A5, count=1.
REQ-024 Continuous, m_ready=0, codes 1..9 -> count reaches 8, ninth sample dropped, overflow=1, pops return 1..8 in order.
REQ-025 Full with m_ready=1 during ninth CAPTURE -> count stays 8, overflow=0, last entry = 9.
REQ-026 start pulsed mid-CONVERT -> ignored; exactly one sample produced.
REQ-027 reset_n low at convert cycle 5 with 3 buffered -> adc_enable 0, count 0, m_valid 0 immediately; no sample after release.
REQ-028 clear_ovf=1 same cycle as a drop -> overflow stays 1; clear_ovf alone next cycle -> overflow 0.
